// File: rtl/fft_reorder_buf_pkg.sv
// fft_reorder_buf_pkg: shared sizes, field slices, flag type and bit-reverse helper.
package fft_reorder_buf_pkg;
  localparam int N = 8;
  localparam int LOG2N = 3;
  localparam int DW = 24;
  localparam int RE_MSB = DW - 1;
  localparam int RE_LSB = DW / 2;
  localparam int IM_MSB = DW / 2 - 1;
  localparam logic [DW/2-1:0] IM_MIN = {1'b1, {(DW/2-1){1'b0}}};
  localparam logic [DW/2-1:0] IM_MAX = ~IM_MIN;
  typedef enum logic {FREE, FULL} flag_e;
  function automatic logic [LOG2N-1:0] bitrev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    for (int i = 0; i < LOG2N; i++) r[i] = a[LOG2N-1-i];
    return r;
  endfunction
endpackage

// File: rtl/fft_reorder_bank.sv
// fft_reorder_bank: N x DW register array, one sync write port, one async read port.
module fft_reorder_bank
  import fft_reorder_buf_pkg::*;
(
  input  logic             clk,
  input  logic             we_i,
  input  logic [LOG2N-1:0] waddr_i,
  input  logic [DW-1:0]    wdata_i,
  input  logic [LOG2N-1:0] raddr_i,
  output logic [DW-1:0]    rdata_o
);
  logic [DW-1:0] mem_q [N];
  always_ff @(posedge clk)
    if (we_i) mem_q[waddr_i] <= wdata_i;
  assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: ping-pong bit-reversed to natural order reorder; FFT_REORDER_CONJ_EN conjugates the output.
module fft_reorder_buf
  import fft_reorder_buf_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_first,
  input  logic [DW-1:0] in_data,
  output logic          out_valid,
  input  logic          out_ready,
  output logic          out_first,
  output logic          out_last,
  output logic [DW-1:0] out_data,
  output logic          frame_err
);
  logic             wbank_q, wbank_d, rbank_q, rbank_d, frame_err_q;
  logic [LOG2N-1:0] wcnt_q, wcnt_d, rcnt_q, rcnt_d, waddr;
  flag_e            flag_q [2];
  flag_e            flag_d [2];
  logic             accept, restart, wdone, xfer, rdone;
  logic [DW-1:0]    rd [2];
  logic [DW-1:0]    rword;
  always_comb begin
    accept  = in_valid && in_ready;
    restart = accept && in_first && wcnt_q != '0;
    wdone   = accept && !restart && wcnt_q == LOG2N'(N-1);
    xfer    = out_valid && out_ready;
    rdone   = xfer && rcnt_q == LOG2N'(N-1);
    waddr   = restart ? '0 : bitrev(wcnt_q);
    wcnt_d  = !accept ? wcnt_q : restart ? LOG2N'(1) : wcnt_q + 1'b1;
    rcnt_d  = xfer ? rcnt_q + 1'b1 : rcnt_q;
    wbank_d = wbank_q ^ wdone;
    rbank_d = rbank_q ^ rdone;
    for (int b = 0; b < 2; b++)
      flag_d[b] = (wdone && wbank_q == b[0]) ? FULL :
                  (rdone && rbank_q == b[0]) ? FREE : flag_q[b];
  end
  always_ff @(posedge clk)
    if (rst) begin
      wbank_q     <= 1'b0;
      rbank_q     <= 1'b0;
      wcnt_q      <= '0;
      rcnt_q      <= '0;
      flag_q[0]   <= FREE;
      flag_q[1]   <= FREE;
      frame_err_q <= 1'b0;
    end else begin
      wbank_q     <= wbank_d;
      rbank_q     <= rbank_d;
      wcnt_q      <= wcnt_d;
      rcnt_q      <= rcnt_d;
      flag_q[0]   <= flag_d[0];
      flag_q[1]   <= flag_d[1];
      frame_err_q <= restart;
    end
  for (genvar g = 0; g < 2; g++) begin : g_bank
    fft_reorder_bank u_bank (
      .clk     (clk),
      .we_i    (accept && wbank_q == 1'(g)),
      .waddr_i (waddr),
      .wdata_i (in_data),
      .raddr_i (rcnt_q),
      .rdata_o (rd[g])
    );
  end
  assign in_ready  = flag_q[wbank_q] == FREE;
  assign out_valid = flag_q[rbank_q] == FULL;
  assign out_first = out_valid && rcnt_q == '0;
  assign out_last  = out_valid && rcnt_q == LOG2N'(N-1);
  assign frame_err = frame_err_q;
  assign rword     = rd[rbank_q];
`ifdef FFT_REORDER_CONJ_EN
  logic [IM_MSB:0] im;
  always_comb begin
    im       = rword[IM_MSB:0];
    out_data = {rword[RE_MSB:RE_LSB], im == IM_MIN ? IM_MAX : -im};
  end
`else
  assign out_data = rword;
`endif
endmodule

// File: tb/tb_fft_reorder_buf.sv
// tb_fft_reorder_buf: randomized + directed stimulus against a frame-level reference scoreboard.
module tb_fft_reorder_buf;
  import fft_reorder_buf_pkg::*;
  logic          clk = 0, rst = 1;
  logic          in_valid = 0, in_first = 0, out_ready = 1;
  logic [DW-1:0] in_data = '0;
  logic          in_ready, out_valid, out_first, out_last, frame_err;
  logic [DW-1:0] out_data;

  fft_reorder_buf dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_first(in_first),
    .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready), .out_first(out_first),
    .out_last(out_last), .out_data(out_data), .frame_err(frame_err)
  );

  always #5 clk = ~clk;

  typedef struct { logic [DW-1:0] d; logic f; logic l; } ent_t;
  ent_t          exp_q [$];
  int            br [8] = '{0, 4, 2, 6, 1, 5, 3, 7};
  logic [DW-1:0] part [8];
  int            pcnt = 0, held = 0, rcount = 0;
  logic          exp_err = 0, rs;
  int            compared = 0, mismatched = 0;
  bit            stop_rand = 0;

  function automatic logic [DW-1:0] xf(input logic [DW-1:0] w);
`ifdef FFT_REORDER_CONJ_EN
    int im;
    im = -int'($signed(w[DW/2-1:0]));
    if (im > 2 ** (DW / 2 - 1) - 1) im = 2 ** (DW / 2 - 1) - 1;
    return {w[DW-1:DW/2], im[DW/2-1:0]};
`else
    return w;
`endif
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Scoreboard: a frame is expected out once all 8 of its samples are in; output in natural bin order.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
      held = 0; pcnt = 0; rcount = 0; exp_err = 0;
    end else begin
      check("in_ready", 32'(in_ready), 32'(held < 2));
      check("out_valid", 32'(out_valid), 32'(held > 0));
      check("frame_err", 32'(frame_err), 32'(exp_err));
      if (out_valid) begin
        if (exp_q.size() == 0) begin
          compared++; mismatched++;
          $display("FAIL unexpected_output: got %h expected none at %0t", out_data, $time);
        end else begin
          check("out_data", 32'(out_data), 32'(exp_q[0].d));
          check("out_first", 32'(out_first), 32'(exp_q[0].f));
          check("out_last", 32'(out_last), 32'(exp_q[0].l));
          if (out_ready) begin
            void'(exp_q.pop_front());
            rcount++;
            if (rcount == N) begin rcount = 0; held--; end
          end
        end
      end else begin
        check("out_first_idle", 32'(out_first), 32'd0);
        check("out_last_idle", 32'(out_last), 32'd0);
      end
      rs = 0;
      if (in_valid && in_ready) begin
        if (in_first && pcnt != 0) begin pcnt = 0; rs = 1; end
        part[br[pcnt]] = in_data;
        pcnt++;
        if (pcnt == N) begin
          for (int k = 0; k < N; k++) exp_q.push_back('{xf(part[k]), k == 0, k == N - 1});
          held++;
          pcnt = 0;
        end
      end
      exp_err = rs;
    end
  end

  task automatic push(input logic [DW-1:0] d, input logic f);
    int w = 0;
    in_valid = 1; in_data = d; in_first = f;
    @(negedge clk);
    while (!in_ready && w < 100) begin @(negedge clk); w++; end
    if (!in_ready) begin
      mismatched++;
      $display("FAIL push_timeout: in_ready stuck 0 at %0t", $time);
    end
    @(posedge clk); #1;
    in_valid = 0; in_first = 0;
  endtask

  task automatic frame_idx();
    for (int p = 0; p < N; p++) push(DW'(br[p]), p == 0);
  endtask

  task automatic frame_rand(input int maxgap);
    for (int p = 0; p < N; p++) begin
      push(DW'($urandom), p == 0);
      repeat ($urandom_range(0, maxgap)) @(posedge clk);
      #0;
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #1 rst = 1;
    @(posedge clk); #1 rst = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1);
  end

  initial begin
    repeat (2) @(posedge clk);
    #1 rst = 0;
    frame_idx();
    repeat (10) @(posedge clk);
    for (int f = 0; f < 4; f++) frame_idx();
    repeat (10) @(posedge clk);
    #1 out_ready = 0;
    fork
      for (int f = 0; f < 3; f++) frame_rand(0);
      begin repeat (20) @(posedge clk); #1 out_ready = 1; end
    join
    repeat (12) @(posedge clk);
    for (int p = 0; p < 3; p++) push(DW'($urandom), p == 0);
    frame_idx();
    repeat (10) @(posedge clk);
    #1 out_ready = 0;
    frame_idx();
    #1 out_ready = 1;
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(posedge clk); #1 rst = 0;
    @(negedge clk);
    check("post_rst_out_valid", 32'(out_valid), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    frame_idx();
    repeat (10) @(posedge clk);
    for (int p = 0; p < N; p++) push({12'h123, p[0] ? 12'h001 : 12'h800}, p == 0);
    repeat (10) @(posedge clk);
    stop_rand = 0;
    fork
      begin
        for (int f = 0; f < 8; f++) begin
          if ($urandom_range(0, 3) == 0)
            for (int p = 0; p < int'($urandom_range(1, 6)); p++) push(DW'($urandom), p == 0);
          frame_rand(2);
        end
        stop_rand = 1;
      end
      while (!stop_rand) begin
        @(posedge clk); #1 out_ready = $urandom_range(0, 3) != 0;
      end
    join
    #1 out_ready = 1;
    repeat (30) @(posedge clk);
    @(negedge clk);
    check("drained_queue", 32'(exp_q.size()), 32'd0);
    check("drained_held", 32'(held), 32'd0);
    do_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
